// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, state encodings, size codes and IO region selector for mem_ctrl
package mem_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] IO_SEL_HI = 2'b11;
  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_IF_READ = 2'd1;
  localparam logic [1:0] MC_LS_READ = 2'd2;
  localparam logic [1:0] MC_LS_WRITE = 2'd3;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] inst_t;
  typedef logic [DATA_W-1:0] data_t;
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    return sz == SZ_BYTE ? 2'd0 : sz == SZ_HALF ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/mc_byte_lane.sv
// mc_byte_lane: byte counter, little-endian read capture and store byte mux for mem_ctrl
//   clk_in/rst_in  clock, sync active-low reset
//   en             global enable, low holds all state
//   start          clears counter and capture register (accept edge)
//   adv            advances the counter; with cap, captures mem_din as byte cnt
//   size/sdata     access size code and latched store data
//   word/last      assembled word, counter at last byte index
//   wbyte_nxt      store byte for the next byte index
module mc_byte_lane
  import mem_ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en,
  input  logic       start,
  input  logic       adv,
  input  logic       cap,
  input  logic [1:0] size,
  input  logic [7:0] mem_din,
  input  data_t      sdata,
  output data_t      word,
  output logic       last,
  output logic [7:0] wbyte_nxt
);
  logic [1:0] cnt_q, cnt_d, nxt;
  data_t word_q, word_d;
  assign nxt = cnt_q + 2'd1;
  assign last = cnt_q == last_idx(size);
  assign wbyte_nxt = sdata[{nxt, 3'b000} +: 8];
  assign word = word_q;
  always_comb begin
    cnt_d = start ? 2'd0 : adv ? nxt : cnt_q;
    word_d = start ? '0 : word_q;
    if (adv && cap) word_d[{cnt_q, 3'b000} +: 8] = mem_din;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q <= 2'd0;
      word_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller serving instruction fetch (word reads) and the LSB (1/2/4-byte reads/writes)
//   clk_in/rst_in/rdy_in/clr_in   clock, sync active-low reset, global enable, ROB flush
//   if_to_mc_* / mc_to_if_*       fetch request in, accept/done pulses and instruction out
//   lsb_to_mc_* / mc_to_lsb_*     LSB request in, accept/done pulses and zero-extended load data out
//   mem_din/mem_a/mem_dout/mem_wr byte-wide RAM/IO bus; io_buffer_full UART back-pressure
//   MC_IO_STALL_EN                when defined, writes into the IO region stall while io_buffer_full
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        if_to_mc_ready,
  input  addr_t       if_to_mc_PC,
  output logic        mc_to_if_valid,
  output logic        mc_to_if_ready,
  output inst_t       mc_to_if_inst,
  input  logic        lsb_to_mc_ready,
  input  logic        lsb_to_mc_wr,
  input  logic [1:0]  lsb_to_mc_size,
  input  addr_t       lsb_to_mc_addr,
  input  data_t       lsb_to_mc_data,
  output logic        mc_to_lsb_valid,
  output logic        mc_to_lsb_ready,
  output data_t       mc_to_lsb_data,
  input  logic [7:0]  mem_din,
  input  logic        io_buffer_full,
  output addr_t       mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr
);
  logic [1:0] state_q, state_d, size_q, size_d;
  data_t data_q, data_d, word;
  addr_t mem_a_q, mem_a_d;
  logic [7:0] mem_dout_q, mem_dout_d, wbyte_nxt;
  logic mem_wr_q, mem_wr_d;
  logic if_valid_q, if_valid_d, if_ready_q, if_ready_d;
  logic lsb_valid_q, lsb_valid_d, lsb_ready_q, lsb_ready_d;
  logic start, adv, last, stall;
`ifdef MC_IO_STALL_EN
  assign stall = state_q == MC_LS_WRITE && io_buffer_full && mem_a_q[17:16] == IO_SEL_HI;
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ (mem_a_q[17:16] == IO_SEL_HI);
  assign stall = 1'b0;
`endif
  mc_byte_lane u_lane (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en       (rdy_in),
    .start    (start),
    .adv      (adv),
    .cap      (state_q != MC_LS_WRITE),
    .size     (size_q),
    .mem_din  (mem_din),
    .sdata    (data_q),
    .word     (word),
    .last     (last),
    .wbyte_nxt(wbyte_nxt)
  );
  always_comb begin
    state_d = state_q;
    size_d = size_q;
    data_d = data_q;
    mem_a_d = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d = mem_wr_q;
    if_valid_d = 1'b0;
    if_ready_d = 1'b0;
    lsb_valid_d = 1'b0;
    lsb_ready_d = 1'b0;
    start = 1'b0;
    adv = 1'b0;
    case (state_q)
      MC_IDLE:
        // a flush only lets committed stores through
        if (lsb_to_mc_ready && (!clr_in || lsb_to_mc_wr)) begin
          state_d = lsb_to_mc_wr ? MC_LS_WRITE : MC_LS_READ;
          lsb_valid_d = 1'b1;
          start = 1'b1;
          size_d = lsb_to_mc_size;
          data_d = lsb_to_mc_data;
          mem_a_d = lsb_to_mc_addr;
          mem_wr_d = lsb_to_mc_wr;
          mem_dout_d = lsb_to_mc_data[7:0];
        end else if (if_to_mc_ready && !clr_in) begin
          state_d = MC_IF_READ;
          if_valid_d = 1'b1;
          start = 1'b1;
          size_d = SZ_WORD;
          mem_a_d = if_to_mc_PC;
        end
      MC_IF_READ, MC_LS_READ:
        if (clr_in) begin
          state_d = MC_IDLE;
          mem_a_d = '0;
        end else begin
          adv = 1'b1;
          state_d = last ? MC_IDLE : state_q;
          mem_a_d = last ? '0 : mem_a_q + 32'd1;
          if_ready_d = last && state_q == MC_IF_READ;
          lsb_ready_d = last && state_q == MC_LS_READ;
        end
      default:
        if (!stall) begin
          adv = 1'b1;
          state_d = last ? MC_IDLE : state_q;
          mem_a_d = last ? '0 : mem_a_q + 32'd1;
          mem_dout_d = last ? mem_dout_q : wbyte_nxt;
          mem_wr_d = !last;
          lsb_ready_d = last;
        end
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= MC_IDLE;
      size_q <= SZ_BYTE;
      data_q <= '0;
      mem_a_q <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_ready_q <= 1'b0;
      lsb_valid_q <= 1'b0;
      lsb_ready_q <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      size_q <= size_d;
      data_q <= data_d;
      mem_a_q <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q <= mem_wr_d;
      if_valid_q <= if_valid_d;
      if_ready_q <= if_ready_d;
      lsb_valid_q <= lsb_valid_d;
      lsb_ready_q <= lsb_ready_d;
    end
  end
  assign mem_a = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr = mem_wr_q & rdy_in & ~stall;
  assign mc_to_if_valid = if_valid_q;
  assign mc_to_if_ready = if_ready_q;
  assign mc_to_lsb_valid = lsb_valid_q;
  assign mc_to_lsb_ready = lsb_ready_q;
  assign mc_to_if_inst = if_ready_q ? word : '0;
  assign mc_to_lsb_data = lsb_ready_q ? word : '0;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checking of mem_ctrl against a transaction-level model
module tb_mem_ctrl;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clr_in = 1'b0;
  logic if_req = 1'b0, lsb_req = 1'b0, lsb_wr = 1'b0, io_full = 1'b0;
  logic [31:0] pc = '0, lsb_a = '0, lsb_d = '0;
  logic [1:0] lsb_sz = '0;
  logic [7:0] mem_din = '0;
  logic mc_to_if_valid, mc_to_if_ready, mc_to_lsb_valid, mc_to_lsb_ready, mem_wr;
  logic [31:0] mc_to_if_inst, mc_to_lsb_data, mem_a;
  logic [7:0] mem_dout;
  int checks = 0, failures = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .if_to_mc_ready(if_req), .if_to_mc_PC(pc),
    .mc_to_if_valid(mc_to_if_valid), .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
    .lsb_to_mc_ready(lsb_req), .lsb_to_mc_wr(lsb_wr), .lsb_to_mc_size(lsb_sz),
    .lsb_to_mc_addr(lsb_a), .lsb_to_mc_data(lsb_d),
    .mc_to_lsb_valid(mc_to_lsb_valid), .mc_to_lsb_ready(mc_to_lsb_ready), .mc_to_lsb_data(mc_to_lsb_data),
    .mem_din(mem_din), .io_buffer_full(io_full),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : (a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5c);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // Model: one outstanding transaction described by kind, base address, last byte index
  // and how many bytes have been moved (m_j); outputs follow from those numbers.
  bit m_busy, m_vif, m_vlsb, m_rif, m_rlsb;
  int m_kind, m_n, m_j;
  logic [31:0] m_addr, m_wd, m_rdata, m_out;

  function automatic bit m_stall();
`ifdef MC_IO_STALL_EN
    logic [31:0] a;
    a = m_addr + 32'(m_j);
    return m_busy && m_kind == 2 && io_full && a[17:16] == 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_accept(input int k, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    m_busy = 1; m_kind = k; m_addr = a; m_wd = d; m_j = 0;
    m_n = sz == 2'b00 ? 0 : sz == 2'b01 ? 1 : 3;
    m_rdata = '0;
    for (int i = 0; i <= m_n; i++) m_rdata = m_rdata | (32'(rd(a + 32'(i))) << (8 * i));
  endtask

  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    if (!rst_in) begin
      m_busy = 0; m_vif = 0; m_vlsb = 0; m_rif = 0; m_rlsb = 0; m_out = '0;
    end else if (rdy_in) begin
      m_vif = 0; m_vlsb = 0; m_rif = 0; m_rlsb = 0;
      if (m_busy) begin
        if (m_kind != 2 && clr_in) m_busy = 0;
        else if (!m_stall()) begin
          m_j++;
          if (m_j == m_n + 1) begin
            m_busy = 0;
            if (m_kind == 0) m_rif = 1; else m_rlsb = 1;
            m_out = m_kind == 2 ? '0 : m_rdata;
          end
        end
      end else if (lsb_req && (!clr_in || lsb_wr)) begin
        m_accept(lsb_wr ? 2 : 1, lsb_a, lsb_sz, lsb_d);
        m_vlsb = 1;
      end else if (if_req && !clr_in) begin
        m_accept(0, pc, 2'b10, '0);
        m_vif = 1;
      end
    end
  end

  always @(negedge clk_in) mem_din = rd(mem_a);

  always @(negedge clk_in) begin
    logic exp_wr;
    exp_wr = m_busy && m_kind == 2 && rdy_in && !m_stall();
    chk("mem_a", mem_a, m_busy ? m_addr + 32'(m_j) : 32'd0);
    chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
    if (exp_wr) chk("mem_dout", 32'(mem_dout), 32'(8'(m_wd >> (8 * m_j))));
    chk("if_valid", 32'(mc_to_if_valid), 32'(m_vif));
    chk("if_ready", 32'(mc_to_if_ready), 32'(m_rif));
    chk("if_inst", mc_to_if_inst, m_rif ? m_out : 32'd0);
    chk("lsb_valid", 32'(mc_to_lsb_valid), 32'(m_vlsb));
    chk("lsb_ready", 32'(mc_to_lsb_ready), 32'(m_rlsb));
    chk("lsb_data", mc_to_lsb_data, m_rlsb ? m_out : 32'd0);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_rdy(input bit lsb, output int lat);
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (lsb ? mc_to_lsb_ready : mc_to_if_ready) break;
    end
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 255));
      1: return 32'h30000 + 32'($urandom_range(0, 7));
      2: return 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    bit seen;
    repeat (3) step();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_pulses", {28'd0, mc_to_if_valid, mc_to_if_ready, mc_to_lsb_valid, mc_to_lsb_ready}, 32'd0);
    chk("rst_data", mc_to_if_inst | mc_to_lsb_data, 32'd0);
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2000] = 8'h37; ram[32'h2001] = 8'h12; ram[32'h2002] = 8'h00; ram[32'h2003] = 8'h00;
    ram[32'h20] = 8'hAB;
    rst_in = 1;
    if_req = 1; pc = 32'h1000;
    step();
    chk("t1_valid", 32'(mc_to_if_valid), 32'd1);
    chk("t1_a0", mem_a, 32'h1000);
    if_req = 0;
    wait_rdy(0, lat);
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_inst", mc_to_if_inst, 32'h00000513);
    step();
    lsb_req = 1; lsb_wr = 0; lsb_sz = 2'b00; lsb_a = 32'h20;
    if_req = 1; pc = 32'h1000;
    step();
    chk("t2_lsb_first", {30'd0, mc_to_lsb_valid, mc_to_if_valid}, 32'd2);
    lsb_req = 0;
    step();
    chk("t2_lsb_ready", 32'(mc_to_lsb_ready), 32'd1);
    chk("t2_lsb_data", mc_to_lsb_data, 32'h000000AB);
    step();
    chk("t2_if_valid", 32'(mc_to_if_valid), 32'd1);
    if_req = 0;
    wait_rdy(0, lat);
    chk("t2_if_lat", 32'(lat), 32'd4);
    chk("t2_if_inst", mc_to_if_inst, 32'h00000513);
    step();
    lsb_req = 1; lsb_wr = 1; lsb_sz = 2'b01; lsb_a = 32'h100; lsb_d = 32'h0000BEEF;
    step();
    chk("t3_e0", {mem_a[15:0], mem_dout, 7'd0, mem_wr}, {16'h0100, 8'hEF, 8'h01});
    lsb_req = 0;
    step();
    chk("t3_e1", {mem_a[15:0], mem_dout, 7'd0, mem_wr}, {16'h0101, 8'hBE, 8'h01});
    step();
    chk("t3_e2", {30'd0, mem_wr, mc_to_lsb_ready}, 32'd1);
    chk("t3_ram", {16'd0, rd(32'h101), rd(32'h100)}, 32'h0000BEEF);
    step();
    if_req = 1; pc = 32'h1000;
    step();
    if_req = 0;
    step();
    clr_in = 1;
    step();
    clr_in = 0;
    chk("t4_abort_a", mem_a, 32'd0);
    seen = 0;
    repeat (6) begin
      step();
      seen = seen | mc_to_if_ready;
    end
    chk("t4_no_ready", 32'(seen), 32'd0);
    if_req = 1; pc = 32'h2000;
    step();
    chk("t4_refetch_valid", 32'(mc_to_if_valid), 32'd1);
    if_req = 0;
    wait_rdy(0, lat);
    chk("t4_refetch_lat", 32'(lat), 32'd4);
    chk("t4_refetch_inst", mc_to_if_inst, 32'h00001237);
    step();
    lsb_req = 1; lsb_wr = 1; lsb_sz = 2'b10; lsb_a = 32'h30000; lsb_d = 32'h11223344;
    step();
    lsb_req = 0;
    clr_in = 1;
    step();
    clr_in = 0;
    wait_rdy(1, lat);
    chk("t5_lat", 32'(lat), 32'd3);
    chk("t5_ram", {rd(32'h30003), rd(32'h30002), rd(32'h30001), rd(32'h30000)}, 32'h11223344);
`ifdef MC_IO_STALL_EN
    step();
    io_full = 1;
    lsb_req = 1; lsb_wr = 1; lsb_sz = 2'b00; lsb_a = 32'h30000; lsb_d = 32'h0000005A;
    step();
    lsb_req = 0;
    chk("t6_stall0", 32'(mem_wr), 32'd0);
    step();
    chk("t6_stall1", 32'(mem_wr), 32'd0);
    step();
    chk("t6_stall2", 32'(mem_wr), 32'd0);
    io_full = 0;
    #1;
    chk("t6_write", 32'(mem_wr), 32'd1);
    step();
    chk("t6_ready", 32'(mc_to_lsb_ready), 32'd1);
    chk("t6_ram", 32'(rd(32'h30000)), 32'h5A);
`endif
    step();
    repeat (4000) begin
      rst_in = $urandom_range(0, 299) != 0;
      rdy_in = $urandom_range(0, 7) != 0;
      clr_in = $urandom_range(0, 19) == 0;
      io_full = $urandom_range(0, 3) == 0;
      if (if_req && mc_to_if_valid) if_req = 0;
      else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1;
        pc = raddr();
      end
      if (lsb_req && mc_to_lsb_valid) lsb_req = 0;
      else if (!lsb_req && $urandom_range(0, 3) == 0) begin
        lsb_req = 1;
        lsb_wr = 1'($urandom_range(0, 1));
        lsb_sz = 2'($urandom_range(0, 2));
        lsb_a = raddr();
        lsb_d = $urandom;
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
